// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI boot-flash responder.
// Holds the FSM state encoding, the opcode, address widths and the bit-index helper.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam int         ADDR_W    = 24;
    localparam int         MEM_AW    = ADDR_W - 2;
    localparam int         BIT_CNT_W = 5;
    localparam int         BIT_PTR_W = 3;
    localparam int         BYTE_PTR_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        FETCH,
        DATA,
        IGNORE
    } state_e;

    // Byte 0 of a word lives in bits [31:24], so the byte pointer is inverted.
    function automatic logic [4:0] word_bit_idx(input logic [BYTE_PTR_W-1:0] byte_ptr,
                                                input logic [BIT_PTR_W-1:0]  bit_ptr);
        return {~byte_ptr, bit_ptr};
    endfunction

endpackage

// File: rtl/spi_sck_edge_det.sv
// Registers the serial clock and reports its rising/falling edges,
// suppressing both whenever chip select is deasserted.
module spi_sck_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_ss,
    output logic rise,
    output logic fall
);

    logic sck_q;
    logic sck_d;

    assign sck_d = spi_sck;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_d;
        end
    end

    assign rise = spi_sck & ~sck_q & ~spi_ss;
    assign fall = ~spi_sck & sck_q & ~spi_ss;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash model: decodes READ + 24-bit address, fetches words from a
// backing memory and streams bytes MSB-first on MISO with word prefetch.
module spi_flash_responder
    import spi_flash_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    state_e                  state_q, state_d;
    logic                    armed_q, armed_d;
    logic [6:0]              cmd_q, cmd_d;
    logic [ADDR_W-2:0]       addr_q, addr_d;
    logic [BIT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_PTR_W-1:0]    bit_ptr_q, bit_ptr_d;
    logic [BYTE_PTR_W-1:0]   byte_ptr_q, byte_ptr_d;
    logic [MEM_AW-1:0]       word_addr_q, word_addr_d;
    logic [MEM_AW-1:0]       mem_addr_q, mem_addr_d;
    logic [31:0]             word_q, word_d;
    logic [31:0]             stage_q, stage_d;
    logic                    miso_q, miso_d;
    logic                    rd_en_q, rd_en_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rise_seen_q, rise_seen_d;

    logic                    rise;
    logic                    fall;
    logic [7:0]              cmd_next;
    logic [ADDR_W-1:0]       addr_next;
    logic                    cmd_done;
    logic                    addr_done;

    spi_sck_edge_det u_edge_det (
        .clock   (clock),
        .reset   (reset),
        .spi_sck (spi_sck),
        .spi_ss  (spi_ss),
        .rise    (rise),
        .fall    (fall)
    );

    assign cmd_next  = {cmd_q, spi_mosi};
    assign addr_next = {addr_q, spi_mosi};
    assign cmd_done  = rise && (cnt_q == BIT_CNT_W'(7));
    assign addr_done = rise && (cnt_q == BIT_CNT_W'(23));

    assign spi_miso  = miso_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = mem_addr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new command only starts after chip select has been seen high since reset.
    always_comb begin
        state_d = state_q;
        if (spi_ss) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (armed_q) state_d = CMD;
                CMD:     if (cmd_done) state_d = (cmd_next == CMD_READ) ? ADDR : IGNORE;
                ADDR:    if (addr_done) state_d = FETCH;
                FETCH:   if (rd_valid_q) state_d = DATA;
                DATA:    state_d = DATA;
                IGNORE:  state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        armed_d     = armed_q | spi_ss;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        bit_ptr_d   = bit_ptr_q;
        byte_ptr_d  = byte_ptr_q;
        word_addr_d = word_addr_q;
        mem_addr_d  = mem_addr_q;
        word_d      = word_q;
        stage_d     = stage_q;
        miso_d      = miso_q;
        rd_en_d     = 1'b0;
        rd_valid_d  = rd_en_q;
        rise_seen_d = rise_seen_q;

        if (spi_ss) begin
            cmd_d       = '0;
            addr_d      = '0;
            cnt_d       = '0;
            bit_ptr_d   = '0;
            byte_ptr_d  = '0;
            miso_d      = 1'b0;
            rise_seen_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    miso_d = 1'b0;
                end
                CMD: begin
                    miso_d = 1'b0;
                    if (rise) begin
                        cmd_d = cmd_next[6:0];
                        cnt_d = cmd_done ? '0 : cnt_q + BIT_CNT_W'(1);
                    end
                end
                ADDR: begin
                    miso_d = 1'b0;
                    if (rise) begin
                        addr_d = addr_next[ADDR_W-2:0];
                        cnt_d  = cnt_q + BIT_CNT_W'(1);
                        if (addr_done) begin
                            cnt_d       = '0;
                            rd_en_d     = 1'b1;
                            mem_addr_d  = addr_next[ADDR_W-1:2];
                            word_addr_d = addr_next[ADDR_W-1:2];
                            byte_ptr_d  = addr_next[1:0];
                            bit_ptr_d   = 3'd7;
                        end
                    end
                end
                FETCH: begin
                    rise_seen_d = 1'b0;
                    if (rd_valid_q) begin
                        word_d = mem_rdata;
                        miso_d = mem_rdata[word_bit_idx(byte_ptr_q, 3'd7)];
                    end
                end
                DATA: begin
                    if (rd_valid_q) begin
                        stage_d = mem_rdata;
                    end
                    if (rise) begin
                        rise_seen_d = 1'b1;
                    end
                    // The fall closing the last address bit arrives before any data rise and is skipped.
                    if (fall && rise_seen_q) begin
                        rise_seen_d = 1'b0;
                        if (bit_ptr_q != 3'd0) begin
                            bit_ptr_d = bit_ptr_q - 3'd1;
                            miso_d    = word_q[word_bit_idx(byte_ptr_q, bit_ptr_q - 3'd1)];
                            if (byte_ptr_q == 2'd3 && bit_ptr_q == 3'd7) begin
                                rd_en_d    = 1'b1;
                                mem_addr_d = word_addr_q + MEM_AW'(1);
                            end
                        end else if (byte_ptr_q == 2'd3) begin
                            word_addr_d = word_addr_q + MEM_AW'(1);
                            byte_ptr_d  = 2'd0;
                            bit_ptr_d   = 3'd7;
                            word_d      = stage_q;
                            miso_d      = stage_q[31];
                        end else begin
                            byte_ptr_d = byte_ptr_q + 2'd1;
                            bit_ptr_d  = 3'd7;
                            miso_d     = word_q[word_bit_idx(byte_ptr_q + 2'd1, 3'd7)];
                        end
                    end
                end
                IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    miso_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed_q     <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            bit_ptr_q   <= '0;
            byte_ptr_q  <= '0;
            word_addr_q <= '0;
            mem_addr_q  <= '0;
            word_q      <= '0;
            stage_q     <= '0;
            miso_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rise_seen_q <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            bit_ptr_q   <= bit_ptr_d;
            byte_ptr_q  <= byte_ptr_d;
            word_addr_q <= word_addr_d;
            mem_addr_q  <= mem_addr_d;
            word_q      <= word_d;
            stage_q     <= stage_d;
            miso_q      <= miso_d;
            rd_en_q     <= rd_en_d;
            rd_valid_q  <= rd_valid_d;
            rise_seen_q <= rise_seen_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: a bus-level SPI master drives reads,
// monitors compare received MISO words and memory read strobes against queues.
module tb_spi_flash_responder;

    localparam int HALF = 4;

    typedef struct {
        logic [21:0] addr;
        int          lo;
        int          hi;
    } rd_exp_t;

    logic        clock;
    logic        reset;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_rd_en;
    logic [21:0] mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:7];
    logic [31:0] exp_data_q [$];
    rd_exp_t     exp_rd_q [$];

    int          checks;
    int          errors;
    int          rx_bits;
    int          zero_viol;
    logic [31:0] rx_sr;
    logic        prev_rd_en;
    logic        data_phase;
    logic        hdr_phase;

    spi_flash_responder dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Backing memory answers one cycle after the strobe.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[2:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    always @(posedge spi_sck) begin
        if (!spi_ss && hdr_phase && spi_miso !== 1'b0) zero_viol++;
        if (spi_ss || !data_phase) begin
            rx_bits = 0;
        end else begin
            rx_sr = {rx_sr[30:0], spi_miso};
            rx_bits++;
            if (rx_bits % 32 == 0) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word actual=%h required=none", rx_sr);
                end else begin
                    checkOutput("miso_word", rx_sr, exp_data_q.pop_front());
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset && mem_rd_en) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_read actual=addr%h required=no_read", mem_addr);
            end else begin
                rd_exp_t e;
                e = exp_rd_q.pop_front();
                checkOutput("rd_addr", {10'd0, mem_addr}, {10'd0, e.addr});
                checks++;
                if (rx_bits < e.lo || rx_bits > e.hi || prev_rd_en) begin
                    errors++;
                    $display("[TB] FAIL rd_timing actual=bit%0d/prev%0b required=bit%0d..%0d/prev0",
                             rx_bits, prev_rd_en, e.lo, e.hi);
                end
            end
        end
        prev_rd_en = mem_rd_en;
    end

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        repeat (HALF) @(negedge clock);
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clock);
        spi_sck = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr,
                                 input int addr_bits, input int data_bits,
                                 input bit collect, input bit zero_all, input bit end_ss);
        spi_ss = 1'b0;
        repeat (3) @(negedge clock);
        hdr_phase = 1'b1;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i]);
        for (int i = 0; i < addr_bits; i++) spi_bit(addr[23-i]);
        hdr_phase  = zero_all;
        data_phase = collect;
        for (int i = 0; i < data_bits; i++) spi_bit(1'b0);
        repeat (HALF) @(negedge clock);
        data_phase = 1'b0;
        hdr_phase  = 1'b0;
        if (end_ss) begin
            spi_ss = 1'b1;
            repeat (4) @(negedge clock);
        end
    endtask

    function automatic rd_exp_t rd(input logic [21:0] a, input int lo, input int hi);
        rd_exp_t r;
        r.addr = a;
        r.lo   = lo;
        r.hi   = hi;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0; errors = 0; zero_viol = 0; rx_bits = 0; rx_sr = '0; prev_rd_en = 1'b0;
        data_phase = 1'b0; hdr_phase = 1'b0;
        mem[0] = 32'h11223344; mem[1] = 32'h55667788; mem[2] = 32'h99AABBCC; mem[3] = 32'hA5A5A5A5;
        mem[4] = 32'h5A5A5A5A; mem[5] = 32'h0F0F0F0F; mem[6] = 32'hF0F0F0F0; mem[7] = 32'hCAFEF00D;
        mem_rdata = '0;
        reset = 1'b0; spi_ss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_miso", {31'd0, spi_miso}, 32'd0);
        checkOutput("reset_rd_en", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("reset_mem_addr", {10'd0, mem_addr}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        $display("[TB] single word read at 0x000000");
        exp_rd_q.push_back(rd(22'd0, 0, 0));
        exp_rd_q.push_back(rd(22'd1, 24, 31));
        exp_data_q.push_back(32'h11223344);
        applyStimulus(8'h03, 24'h000000, 24, 32, 1, 0, 1);

        $display("[TB] continuous two-word read");
        exp_rd_q.push_back(rd(22'd0, 0, 0));
        exp_rd_q.push_back(rd(22'd1, 24, 31));
        exp_rd_q.push_back(rd(22'd2, 56, 63));
        exp_data_q.push_back(32'h11223344);
        exp_data_q.push_back(32'h55667788);
        applyStimulus(8'h03, 24'h000000, 24, 64, 1, 0, 1);

        $display("[TB] unaligned read at 0x000002");
        exp_rd_q.push_back(rd(22'd0, 0, 0));
        exp_rd_q.push_back(rd(22'd1, 8, 15));
        exp_data_q.push_back(32'h33445566);
        applyStimulus(8'h03, 24'h000002, 24, 32, 1, 0, 1);

        $display("[TB] unsupported opcode 0x9F");
        applyStimulus(8'h9F, 24'hABCDEF, 24, 24, 0, 1, 1);
        checkOutput("ignore_miso_zero", zero_viol, 0);
        exp_rd_q.push_back(rd(22'd0, 0, 0));
        exp_rd_q.push_back(rd(22'd1, 24, 31));
        exp_data_q.push_back(32'h11223344);
        applyStimulus(8'h03, 24'h000000, 24, 32, 1, 0, 1);

        $display("[TB] aborted address then read at 0x000004");
        applyStimulus(8'h03, 24'hFFFFFF, 10, 0, 0, 0, 1);
        exp_rd_q.push_back(rd(22'd1, 0, 0));
        exp_rd_q.push_back(rd(22'd2, 24, 31));
        exp_data_q.push_back(32'h55667788);
        applyStimulus(8'h03, 24'h000004, 24, 32, 1, 0, 1);

        $display("[TB] address wrap at 0xFFFFFC");
        exp_rd_q.push_back(rd(22'h3FFFFF, 0, 0));
        exp_rd_q.push_back(rd(22'd0, 24, 31));
        exp_rd_q.push_back(rd(22'd1, 56, 63));
        exp_data_q.push_back(32'hCAFEF00D);
        exp_data_q.push_back(32'h11223344);
        applyStimulus(8'h03, 24'hFFFFFC, 24, 64, 1, 0, 1);

        $display("[TB] reset during data phase");
        exp_rd_q.push_back(rd(22'd0, 0, 0));
        applyStimulus(8'h03, 24'h000000, 24, 14, 0, 0, 0);
        repeat (2) @(negedge clock);
        checkOutput("miso_pre_reset", {31'd0, spi_miso}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_miso", {31'd0, spi_miso}, 32'd0);
        checkOutput("async_reset_rd_en", {31'd0, mem_rd_en}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        applyStimulus(8'h03, 24'h000000, 24, 8, 0, 1, 1);
        checkOutput("unarmed_miso_zero", zero_viol, 0);
        exp_rd_q.push_back(rd(22'd0, 0, 0));
        exp_rd_q.push_back(rd(22'd1, 24, 31));
        exp_data_q.push_back(32'h11223344);
        applyStimulus(8'h03, 24'h000000, 24, 32, 1, 0, 1);

        repeat (10) @(negedge clock);
        checkOutput("all_reads_seen", exp_rd_q.size(), 0);
        checkOutput("all_words_seen", exp_data_q.size(), 0);
        checkOutput("header_miso_zero", zero_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
